vect_result_serializer: RTL and testbench



---
 rtl/vect_result_serializer_if.sv | 44 ++++
 rtl/vect_result_serializer.sv | 180 ++++++++++++++++++
 tb/tb_vect_result_serializer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vect_result_serializer_if.sv
// Handshake bundle for vect_result_serializer: vector capture side and scalar write-beat side.
// lane_mask is present only when VSER_MASK_EN is defined.
interface vect_result_serializer_if #(
  parameter int unsigned N      = 24,
  parameter int unsigned M      = 6,
  parameter int unsigned ADDR_W = 16
);
  localparam int unsigned IDX_W = $clog2(M);

  logic              in_valid;
  logic              in_ready;
  logic [M*N-1:0]    in_result;
  logic [1:0]        in_flags;
  logic [ADDR_W-1:0] in_base_addr;
`ifdef VSER_MASK_EN
  logic [M-1:0]      lane_mask;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_data;
  logic [ADDR_W-1:0] out_addr;
  logic [IDX_W-1:0]  out_lane;
  logic              out_last;

`ifdef VSER_MASK_EN
  modport master (
    output in_valid, in_result, in_flags, in_base_addr, lane_mask, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_lane, out_last
  );
  modport slave (
    input  in_valid, in_result, in_flags, in_base_addr, lane_mask, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_lane, out_last
  );
`else
  modport master (
    output in_valid, in_result, in_flags, in_base_addr, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_lane, out_last
  );
  modport slave (
    input  in_valid, in_result, in_flags, in_base_addr, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_lane, out_last
  );
`endif
endinterface

// File: rtl/vect_result_serializer.sv
// Captures an M-lane vector result and drains it as one scalar write beat per cycle.
// Optional feature: VSER_MASK_EN adds a per-lane write mask sampled at acceptance.
module vect_result_serializer #(
  parameter int unsigned N         = 24,
  parameter int unsigned M         = 6,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vect_result_serializer_if.slave bus,
  output logic                    busy,
  output logic [1:0]              flags_q
);
  localparam int unsigned IDX_W = $clog2(M);
  localparam int unsigned VEC_W = M * N;

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t            state_q, state_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [VEC_W-1:0]  vec_q, vec_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [M-1:0]      mask_q, mask_n;
  logic [1:0]        flags_n;
  logic              busy_n;
  logic              in_ready_q, in_ready_n;
  logic              out_valid_q, out_valid_n;
  logic [N-1:0]      out_data_q, out_data_n;
  logic [ADDR_W-1:0] out_addr_q, out_addr_n;
  logic [IDX_W-1:0]  out_lane_q, out_lane_n;
  logic              out_last_q, out_last_n;

  logic [M-1:0]      acc_mask;
  logic              acc_found;
  logic [IDX_W-1:0]  acc_idx;
  logic [IDX_W-1:0]  nxt_idx;

`ifdef VSER_MASK_EN
  assign acc_mask = bus.lane_mask;
`else
  assign acc_mask = '1;
`endif

  // Lowest set mask bit at or above start (0 when none).
  function automatic logic [IDX_W-1:0] find_idx(input logic [M-1:0] m, input int start);
    logic             found;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(M); i++) begin
      if (!found && m[i] && (i >= start)) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic any_from(input logic [M-1:0] m, input int start);
    logic found;
    found = 1'b0;
    for (int i = 0; i < int'(M); i++) begin
      if (m[i] && (i >= start)) found = 1'b1;
    end
    return found;
  endfunction

  function automatic logic [N-1:0] lane_of(input logic [VEC_W-1:0] v, input logic [IDX_W-1:0] i);
    return v[32'(i) * N +: N];
  endfunction

  // Address wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [IDX_W-1:0] i);
    logic [31:0] off;
    off = 32'(i) * ADDR_STEP;
    return b + off[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vec_q       <= '0;
      base_q      <= '0;
      mask_q      <= '0;
      flags_q     <= '0;
      busy        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      vec_q       <= vec_n;
      base_q      <= base_n;
      mask_q      <= mask_n;
      flags_q     <= flags_n;
      busy        <= busy_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
      out_data_q  <= out_data_n;
      out_addr_q  <= out_addr_n;
      out_lane_q  <= out_lane_n;
      out_last_q  <= out_last_n;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    vec_n       = vec_q;
    base_n      = base_q;
    mask_n      = mask_q;
    flags_n     = flags_q;
    busy_n      = busy;
    in_ready_n  = in_ready_q;
    out_valid_n = out_valid_q;
    out_data_n  = out_data_q;
    out_addr_n  = out_addr_q;
    out_lane_n  = out_lane_q;
    out_last_n  = out_last_q;

    acc_found = any_from(acc_mask, 0);
    acc_idx   = find_idx(acc_mask, 0);
    nxt_idx   = find_idx(mask_q, int'(idx_q) + 1);

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_n     = SEND;
          vec_n       = bus.in_result;
          base_n      = bus.in_base_addr;
          mask_n      = acc_mask;
          flags_n     = bus.in_flags;
          busy_n      = 1'b1;
          in_ready_n  = 1'b0;
          idx_n       = acc_idx;
          out_valid_n = acc_found;
          out_data_n  = lane_of(bus.in_result, acc_idx);
          out_addr_n  = lane_addr(bus.in_base_addr, acc_idx);
          out_lane_n  = acc_idx;
          out_last_n  = acc_found && !any_from(acc_mask, int'(acc_idx) + 1);
        end
      end
      SEND: begin
        // An empty-mask vector leaves out_valid low and retires after one cycle.
        if (!out_valid_q || bus.out_ready) begin
          if (!out_valid_q || out_last_q) begin
            state_n     = IDLE;
            busy_n      = 1'b0;
            in_ready_n  = 1'b1;
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
          end else begin
            idx_n      = nxt_idx;
            out_data_n = lane_of(vec_q, nxt_idx);
            out_addr_n = lane_addr(base_q, nxt_idx);
            out_lane_n = nxt_idx;
            out_last_n = !any_from(mask_q, int'(nxt_idx) + 1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_lane  = out_lane_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_vect_result_serializer.sv
// Directed, table-driven bench for vect_result_serializer (default build; masked
// sequences are added when VSER_MASK_EN is defined).
module tb_vect_result_serializer;
  localparam int unsigned N      = 24;
  localparam int unsigned M      = 6;
  localparam int unsigned ADDR_W = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] flags_q;

  int vectors     = 0;
  int miscompares = 0;

  vect_result_serializer_if #(.N(N), .M(M), .ADDR_W(ADDR_W)) bus ();

  vect_result_serializer #(.N(N), .M(M), .ADDR_W(ADDR_W), .ADDR_STEP(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .flags_q (flags_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][23:0] lanes;
    logic [15:0]      base;
    logic [1:0]       flags;
    logic [15:0]      rdy_pat;
    logic             poke;
    logic [7:0]       cycles;
    logic [5:0][15:0] addrs;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one vector, drain it under the record's out_ready pattern, check every beat.
  task automatic run_vec(input vec_t t);
    int beat;
    int cyc;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid     = 1'b1;
    bus.in_result    = t.lanes;
    bus.in_base_addr = t.base;
    bus.in_flags     = t.flags;
    bus.out_ready    = 1'b0;
    @(negedge clk);
    beat = 0;
    cyc  = 0;
    while (beat < 6 && cyc < 60) begin
      if (t.poke && cyc < 3) begin
        bus.in_valid  = 1'b1;
        bus.in_flags  = ~t.flags;
        bus.in_result = '0;
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      end else begin
        bus.in_valid = 1'b0;
      end
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("out_data", 32'(bus.out_data), 32'(t.lanes[beat]));
      chk("out_addr", 32'(bus.out_addr), 32'(t.addrs[beat]));
      chk("out_lane", 32'(bus.out_lane), 32'(beat));
      chk("out_last", 32'(bus.out_last), 32'(beat == 5));
      chk("busy", 32'(busy), 32'd1);
      chk("flags_q_held", 32'(flags_q), 32'(t.flags));
      bus.out_ready = t.rdy_pat[cyc % 16];
      if (bus.out_ready) beat++;
      cyc++;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("beat_count", 32'(beat), 32'd6);
    chk("drain_cycles", 32'(cyc), 32'(t.cycles));
    chk("out_valid_done", 32'(bus.out_valid), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    chk("in_ready_done", 32'(bus.in_ready), 32'd1);
    chk("flags_q_done", 32'(flags_q), 32'(t.flags));
  endtask

  initial begin
    tbl[0] = '{lanes: {24'h000006, 24'h000005, 24'h000004, 24'h000003, 24'h000002, 24'h000001},
               base: 16'h0100, flags: 2'b10, rdy_pat: 16'hFFFF, poke: 1'b0, cycles: 8'd6,
               addrs: {16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100}};
    tbl[1] = '{lanes: {24'h7FFFFE, 24'h800001, 24'h000000, 24'hFFFFFF, 24'h123456, 24'hABCDEF},
               base: 16'h2000, flags: 2'b01, rdy_pat: 16'h9999, poke: 1'b1, cycles: 8'd12,
               addrs: {16'h2005, 16'h2004, 16'h2003, 16'h2002, 16'h2001, 16'h2000}};
    tbl[2] = '{lanes: {24'h666666, 24'h555555, 24'h444444, 24'h333333, 24'h222222, 24'h111111},
               base: 16'hFFFE, flags: 2'b11, rdy_pat: 16'hFFFF, poke: 1'b0, cycles: 8'd6,
               addrs: {16'h0003, 16'h0002, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}};
    tbl[3] = '{lanes: {24'hC0FFEE, 24'hBEEF00, 24'h00DEAD, 24'h5A5A5A, 24'hA5A5A5, 24'h010203},
               base: 16'h7FFD, flags: 2'b00, rdy_pat: 16'h5555, poke: 1'b0, cycles: 8'd11,
               addrs: {16'h8002, 16'h8001, 16'h8000, 16'h7FFF, 16'h7FFE, 16'h7FFD}};

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_result    = '0;
    bus.in_flags     = '0;
    bus.in_base_addr = '0;
    bus.out_ready    = 1'b0;
`ifdef VSER_MASK_EN
    bus.lane_mask    = '1;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags_q", 32'(flags_q), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_out_lane", 32'(bus.out_lane), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int v = 0; v < 4; v++) run_vec(tbl[v]);

    // Reset while stalled on lane 2
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.in_result    = tbl[0].lanes;
    bus.in_base_addr = 16'h0300;
    bus.in_flags     = 2'b01;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    chk("mid_lane", 32'(bus.out_lane), 32'd2);
    @(negedge clk);
    chk("mid_lane_stall", 32'(bus.out_lane), 32'd2);
    chk("mid_addr_stall", 32'(bus.out_addr), 32'h0302);
    chk("mid_flags", 32'(flags_q), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_flags_q", 32'(flags_q), 32'd0);
    chk("midrst_out_lane", 32'(bus.out_lane), 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_no_beat", 32'(bus.out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    end

`ifdef VSER_MASK_EN
    begin
      logic [2:0] exp_lane [3];
      exp_lane[0] = 3'd0;
      exp_lane[1] = 3'd2;
      exp_lane[2] = 3'd5;
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.in_result    = tbl[0].lanes;
      bus.in_base_addr = 16'h0040;
      bus.in_flags     = 2'b11;
      bus.lane_mask    = 6'b100101;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
        chk("mask_valid", 32'(bus.out_valid), 32'd1);
        chk("mask_lane", 32'(bus.out_lane), 32'(exp_lane[b]));
        chk("mask_data", 32'(bus.out_data), 32'(exp_lane[b]) + 32'd1);
        chk("mask_addr", 32'(bus.out_addr), 32'h40 + 32'(exp_lane[b]));
        chk("mask_last", 32'(bus.out_last), 32'(b == 2));
        @(negedge clk);
      end
      chk("mask_done_valid", 32'(bus.out_valid), 32'd0);
      chk("mask_done_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_flags  = 2'b01;
      bus.lane_mask = 6'b000000;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("zmask_valid", 32'(bus.out_valid), 32'd0);
      chk("zmask_in_ready", 32'(bus.in_ready), 32'd0);
      chk("zmask_flags", 32'(flags_q), 32'd1);
      @(negedge clk);
      chk("zmask_valid2", 32'(bus.out_valid), 32'd0);
      chk("zmask_in_ready2", 32'(bus.in_ready), 32'd1);
      chk("zmask_busy2", 32'(busy), 32'd0);
      bus.lane_mask = '1;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
